// File: rtl/counter_pkg.sv
// Shared types and defaults for the mode_counter family.
package counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } cnt_dir_e;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } cnt_mode_e;

    localparam int DEFAULT_WIDTH = 64;

endpackage : counter_pkg

// File: rtl/mode_counter_next.sv
// Purely combinational next-count and bound-event computation for one enabled step.
module mode_counter_next
    import counter_pkg::*;
#(
    parameter int          WIDTH = DEFAULT_WIDTH,
    parameter int unsigned STEP  = 1
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] limit,
    input  logic             dir,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] nxt,
    output logic             bound_evt
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    cnt_dir_e         w_dir;
    cnt_mode_e        w_mode;
    logic             w_above;
    logic [WIDTH-1:0] w_headroom;
    logic             w_up_evt;
    logic             w_down_evt;

    assign w_dir  = cnt_dir_e'(dir);
    assign w_mode = cnt_mode_e'(sat_mode);

    // The headroom is only consulted when count <= limit, so the
    // subtraction never wraps in a way that affects the result.
    assign w_above    = (count > limit);
    assign w_headroom = limit - count;
    assign w_up_evt   = w_above || (w_headroom < STEP_W);
    assign w_down_evt = w_above || (count < STEP_W);

    always_comb begin
        nxt       = count;
        bound_evt = 1'b0;
        case (w_dir)
            DIR_UP: begin
                bound_evt = w_up_evt;
                if (w_up_evt) begin
                    nxt = (w_mode == MODE_SAT) ? limit : '0;
                end else begin
                    nxt = count + STEP_W;
                end
            end
            default: begin
                bound_evt = w_down_evt;
                if (w_down_evt) begin
                    nxt = (w_mode == MODE_SAT) ? '0 : limit;
                end else begin
                    nxt = count - STEP_W;
                end
            end
        endcase
    end

endmodule : mode_counter_next

// File: rtl/mode_counter.sv
// Up/down counter with runtime limit, wrap/saturate modes, clamped load,
// registered terminal-count pulse and sticky overflow flag.
module mode_counter
    import counter_pkg::*;
#(
    parameter int          WIDTH = DEFAULT_WIDTH,
    parameter int unsigned STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic             sat_mode,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf_sticky,
    output logic             at_max,
    output logic             at_zero
);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;

    logic [WIDTH-1:0] w_nxt;
    logic             w_bound_evt;
    logic [WIDTH-1:0] w_load_clamped;

    mode_counter_next #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_next (
        .count     (r_count),
        .limit     (limit),
        .dir       (dir),
        .sat_mode  (sat_mode),
        .nxt       (w_nxt),
        .bound_evt (w_bound_evt)
    );

    assign w_load_clamped = (load_val > limit) ? limit : load_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (clr) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (load) begin
            r_count <= w_load_clamped;
            r_tc    <= 1'b0;
        end else if (en) begin
            r_count <= w_nxt;
            r_tc    <= w_bound_evt;
            r_ovf   <= r_ovf | w_bound_evt;
        end else begin
            r_tc    <= 1'b0;
        end
    end

    assign count      = r_count;
    assign tc         = r_tc;
    assign ovf_sticky = r_ovf;
    assign at_max     = (r_count == limit);
    assign at_zero    = (r_count == '0);

`ifdef FORMAL
    localparam logic [WIDTH-1:0] F_STEP_W = WIDTH'(STEP);

    logic f_past_valid = 1'b0;
    always @(posedge clk) f_past_valid <= 1'b1;

    always @(posedge clk) begin
        if (f_past_valid) begin
            if (tc) assert (ovf_sticky);
            if ($past(rst)) assert (count == '0 && !ovf_sticky);
            if (!$past(rst) && !$past(clr) && !$past(load) && $past(en)
                && !$past(w_bound_evt)) begin
                if ($past(dir))
                    assert (count == $past(count) + F_STEP_W);
                else
                    assert (count == $past(count) - F_STEP_W);
            end
            if (!$past(rst) && ($past(count) <= $past(limit))
                && (limit == $past(limit)))
                assert (count <= limit);
            cover (tc && $past(sat_mode));
            cover (tc && !$past(sat_mode));
        end
    end
`endif

endmodule : mode_counter
